// File: rtl/fir_sym_mac.sv
// fir_sym_mac - time-multiplexed symmetric FIR filter for the ADC sample stream.
//
// One shared multiplier walks the NCOEF = (TAPS+1)/2 unique coefficients,
// pre-adding each mirrored pair of delay-line taps. The result is rounded
// half-up, saturated to [0, 2^OUT_W-1] and presented on a one-cycle strobe.
// One sample is processed every NCOEF+2 cycles.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   sample_valid/in   incoming sample, accepted when sample_ready is high
//   sample_ready      high in IDLE
//   coef_we/addr/wdata  coefficient write port, honoured only in IDLE
//   out_valid         one-cycle strobe, out_data holds until the next result
//   out_data          rounded, saturated filter output
//   out_sat           (FIR_SAT_FLAG_EN only) result was clipped, with out_valid
//   busy              high whenever a computation is in progress
//
// Build option: define FIR_SAT_FLAG_EN to add the out_sat port.
module fir_sym_mac #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 10,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int TAPS   = 31,
  localparam int NCOEF = (TAPS + 1) / 2,
  localparam int AW    = $clog2(NCOEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_ready,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
`ifdef FIR_SAT_FLAG_EN
  output logic              out_sat,
`endif
  output logic              busy
);

  localparam int XW    = $clog2(TAPS);
  localparam int PW    = DATA_W + 1;
  localparam int MW    = COEF_W + PW;
  localparam int ACC_W = DATA_W + 1 + COEF_W + AW;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(2 ** OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

  state_t state;

  logic        [DATA_W-1:0] x [TAPS];
  // Sized to the full address space; entries at or above NCOEF are never
  // read, so writes to them have no effect on the filter.
  logic signed [COEF_W-1:0] c [2**AW];

  logic        [AW-1:0]     k;
  logic signed [ACC_W-1:0]  acc;

  logic                     last_k;
  logic        [XW-1:0]     kmir;
  logic        [PW-1:0]     pre;
  logic signed [MW-1:0]     term;
  logic signed [ACC_W-1:0]  rnd;
  logic                     sat_lo;
  logic                     sat_hi;
  logic        [OUT_W-1:0]  sat_val;

  assign sample_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign last_k       = (k == AW'(NCOEF - 1));

  // Datapath for the current MAC step and the rounding stage.
  always_comb begin
    kmir = XW'(TAPS - 1) - XW'(k);
    pre  = PW'(x[XW'(k)]);
    // The centre tap has no mirror partner.
    if (!last_k) begin
      pre = pre + PW'(x[kmir]);
    end
    term = MW'(c[k]) * MW'($signed({1'b0, pre}));

    rnd    = (acc + HALF) >>> FRAC_W;
    sat_lo = rnd[ACC_W-1];
    sat_hi = !sat_lo && (rnd > OMAX);
    if (sat_lo) begin
      sat_val = '0;
    end else if (sat_hi) begin
      sat_val = '1;
    end else begin
      sat_val = OUT_W'(rnd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FIR_SAT_FLAG_EN
      out_sat   <= 1'b0;
`endif
      for (int unsigned i = 0; i < TAPS; i++) begin
        x[i] <= '0;
      end
      for (int unsigned i = 0; i < 2**AW; i++) begin
        c[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      // Coefficients are frozen while a computation is running.
      if (coef_we && state == IDLE) begin
        c[coef_addr] <= coef_wdata;
      end

      case (state)
        IDLE: begin
          if (sample_valid) begin
            x[0] <= sample_in;
            for (int unsigned i = 1; i < TAPS; i++) begin
              x[i] <= x[i-1];
            end
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(term);
          if (last_k) begin
            state <= ROUND;
          end else begin
            k <= k + 1'b1;
          end
        end
        ROUND: begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
`ifdef FIR_SAT_FLAG_EN
          out_sat   <= sat_lo | sat_hi;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac - directed self-checking bench for fir_sym_mac at default
// parameters. Inputs change and outputs are sampled on the falling edge.
module tb_fir_sym_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_in = '0;
  logic        sample_ready;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        out_valid;
  logic [9:0]  out_data;
  logic        busy;
`ifdef FIR_SAT_FLAG_EN
  logic        out_sat;
`endif

  int ncmp  = 0;
  int nfail = 0;
  int r;
  int last_sat;
  int acc_t [4];
  int ov_t  [3];
  int ov_d  [3];
  int na, no, nb, nstray;

  always #5 clk = ~clk;

  fir_sym_mac #(
    .DATA_W (10),
    .OUT_W  (10),
    .COEF_W (16),
    .FRAC_W (14),
    .TAPS   (31)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .out_valid    (out_valid),
    .out_data     (out_data),
`ifdef FIR_SAT_FLAG_EN
    .out_sat      (out_sat),
`endif
    .busy         (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 16'(data);
    @(negedge clk);
    coef_we    = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int res);
    int unsigned n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_strobe"}, int'(out_valid), 1);
    res = int'(out_data);
`ifdef FIR_SAT_FLAG_EN
    last_sat = int'(out_sat);
`else
    last_sat = 0;
`endif
    @(negedge clk);
  endtask

  task automatic feed(input int s, input string tag, output int res);
    sample_valid = 1'b1;
    sample_in    = 10'(s);
    @(negedge clk);
    sample_valid = 1'b0;
    wait_result(tag, res);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_ready", int'(sample_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    // Centre-tap impulse: 500 appears only on the 16th output.
    wr(15, 16384);
    for (int i = 1; i <= 17; i++) begin
      feed((i == 1) ? 500 : 0, "imp", r);
      chk($sformatf("imp_%0d", i), r, (i == 16) ? 500 : 0);
    end

    // Outer symmetric pair: 100*0.5 on the 1st and 31st outputs.
    do_reset();
    wr(0, 8192);
    for (int i = 1; i <= 31; i++) begin
      feed((i == 1) ? 100 : 0, "pair", r);
      chk($sformatf("pair_%0d", i), r, (i == 1 || i == 31) ? 50 : 0);
    end

    // Rounding: 3*0.5 = 1.5 -> 2.
    do_reset();
    wr(15, 8192);
    for (int i = 1; i <= 16; i++) begin
      feed(3, "rnd", r);
      if (i == 1) chk("rnd_first", r, 0);
    end
    chk("rnd_half_up", r, 2);

    // High saturation: 1000*1.99994 -> 2000 -> 1023.
    do_reset();
    wr(15, 32767);
    for (int i = 1; i <= 16; i++) begin
      feed(1000, "sathi", r);
`ifdef FIR_SAT_FLAG_EN
      if (i == 1) chk("sathi_flag_clear", last_sat, 0);
`endif
    end
    chk("sathi_data", r, 1023);
`ifdef FIR_SAT_FLAG_EN
    chk("sathi_flag", last_sat, 1);
`endif

    // Low saturation: 200*-1.0 -> -200 -> 0.
    do_reset();
    wr(15, -16384);
    for (int i = 1; i <= 16; i++) begin
      feed(200, "satlo", r);
    end
    chk("satlo_data", r, 0);
`ifdef FIR_SAT_FLAG_EN
    chk("satlo_flag", last_sat, 1);
`endif

    // Write and accept in the same IDLE cycle: new coefficient is used.
    do_reset();
    coef_we      = 1'b1;
    coef_addr    = 4'd0;
    coef_wdata   = 16'd16384;
    sample_valid = 1'b1;
    sample_in    = 10'd42;
    @(negedge clk);
    coef_we      = 1'b0;
    sample_valid = 1'b0;
    wait_result("same_cycle", r);
    chk("same_cycle_data", r, 42);

    // Continuous valid: accepts every 18 cycles, result 18 cycles later.
    do_reset();
    wr(0, 16384);
    na = 0; no = 0; nb = 0;
    sample_valid = 1'b1;
    sample_in    = 10'd1;
    for (int t = 0; t < 60; t++) begin
      if (out_valid === 1'b1 && no < 3) begin
        ov_t[no] = t;
        ov_d[no] = int'(out_data);
        no++;
      end
      if (t >= 1 && t <= 18 && busy === 1'b1) nb++;
      if (sample_ready === 1'b1 && na < 4) begin
        acc_t[na] = t;
        na++;
      end
      @(negedge clk);
      sample_in = 10'(na + 1);
    end
    sample_valid = 1'b0;
    chk("hs_accept_count", na, 4);
    chk("hs_result_count", no, 3);
    for (int i = 0; i < 4; i++) begin
      if (i < na) chk($sformatf("hs_accept_t%0d", i), acc_t[i], 18 * i);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < no) begin
        chk($sformatf("hs_result_t%0d", i), ov_t[i], 18 * (i + 1));
        chk($sformatf("hs_result_d%0d", i), ov_d[i], i + 1);
      end
    end
    chk("hs_busy_cycles", nb, 17);

    // Coefficient write during MAC is dropped; in IDLE it takes effect.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      feed(7, "bw_fill", r);
    end
    sample_valid = 1'b1;
    sample_in    = 10'd7;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bw_busy_at_write", int'(busy), 1);
    wr(15, 16384);
    wait_result("bw_dropped", r);
    chk("bw_dropped_data", r, 0);
    wr(15, 16384);
    feed(7, "bw_idle", r);
    chk("bw_idle_data", r, 7);

    // Reset at MAC step 5 aborts cleanly and clears coefficients.
    do_reset();
    wr(0, 16384);
    feed(9, "mr_pre", r);
    chk("mr_pre_data", r, 9);
    sample_valid = 1'b1;
    sample_in    = 10'd4;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    do_reset();
    chk("mr_ready", int'(sample_ready), 1);
    chk("mr_busy", int'(busy), 0);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_out_data", int'(out_data), 0);
    nstray = 0;
    for (int t = 0; t < 25; t++) begin
      if (out_valid !== 1'b0) nstray++;
      @(negedge clk);
    end
    chk("mr_no_stray", nstray, 0);
    feed(5, "mr_post", r);
    chk("mr_coef_cleared", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
